// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and the transmit FSM encoding.
package uart_pkg;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// CPU data-bus port of the UART: byte-offset address, write data/strobes,
// and combinational read data.
interface uart_tx_if;
  logic [3:0]  data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wenable;
  logic [31:0] data_rdata;

  modport master (output data_addr, data_wdata, data_wenable, input data_rdata);
  modport slave  (input data_addr, data_wdata, data_wenable, output data_rdata);
endinterface

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous first-word-fallthrough FIFO; the caller only pushes when legal.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // One extra pointer bit separates full from empty when the indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, DIV/OVF registers,
// TX FIFO and the bit-timing FSM that drives the serial line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int DIV_RESET  = 434
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      tx,
  output logic      irq
);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  tx_state_e            state_q;
  logic                 tx_q;
  logic [DIV_WIDTH-1:0] div_q, div_d, div_eff;
  logic [DIV_WIDTH-1:0] dlat_q, cnt_q;
  logic [2:0]           bit_q;
  logic [7:0]           sh_q;
  logic                 ovf_q, ovf_d;

  logic       push_req, push, pop, full, empty;
  logic [7:0] fifo_rdata;
  logic       div_wr, ovf_clr, busy;
  logic       unused_bits;

  assign unused_bits = ^{bus.data_wdata[31:16], bus.data_wenable[3:2]};

  assign push_req = bus.data_wenable[0] && (bus.data_addr == UART_TXDATA);
  assign div_wr   = (bus.data_addr == UART_DIV);
  assign ovf_clr  = bus.data_wenable[0] && (bus.data_addr == UART_STATUS) && bus.data_wdata[ST_OVF];
  assign busy     = (state_q != S_IDLE);
  assign div_eff  = (div_q == '0) ? ONE : div_q;

  // Pops only come from a registered non-empty, so a push into an empty
  // FIFO can never be popped in the same cycle.
  assign pop  = !empty && ((state_q == S_IDLE) || (state_q == S_STOP && cnt_q == '0));
  assign push = push_req && (!full || pop);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.data_wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    div_d = div_q;
    if (div_wr) begin
      for (int i = 0; i < DIV_WIDTH && i < 16; i++)
        if (bus.data_wenable[i>>3]) div_d[i] = bus.data_wdata[i];
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (push_req && !push) ovf_d = 1'b1;
    else if (ovf_clr)      ovf_d = 1'b0;
  end

  always_comb begin
    bus.data_rdata = '0;
    case (bus.data_addr)
      UART_STATUS: begin
        bus.data_rdata[ST_FULL]  = full;
        bus.data_rdata[ST_EMPTY] = empty;
        bus.data_rdata[ST_BUSY]  = busy;
        bus.data_rdata[ST_OVF]   = ovf_q;
      end
      UART_DIV: bus.data_rdata = 32'(div_q);
      default:  bus.data_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DIV_WIDTH'(DIV_RESET);
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  // cnt_q counts down the cycles left in the current bit; dlat_q holds the
  // divisor captured at frame start so DIV writes only affect later frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      dlat_q  <= ONE;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
            sh_q    <= fifo_rdata;
            dlat_q  <= div_eff;
            cnt_q   <= div_eff - ONE;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            state_q <= S_DATA;
            tx_q    <= sh_q[0];
            sh_q    <= {1'b0, sh_q[7:1]};
            bit_q   <= '0;
            cnt_q   <= dlat_q - ONE;
          end else cnt_q <= cnt_q - ONE;
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= dlat_q - ONE;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q  <= sh_q[0];
              sh_q  <= {1'b0, sh_q[7:1]};
              bit_q <= bit_q + 3'd1;
            end
          end else cnt_q <= cnt_q - ONE;
        end
        S_STOP: begin
          if (cnt_q == '0) begin
            if (!empty) begin
              state_q <= S_START;
              tx_q    <= 1'b0;
              sh_q    <= fifo_rdata;
              dlat_q  <= div_eff;
              cnt_q   <= div_eff - ONE;
            end else state_q <= S_IDLE;
          end else cnt_q <= cnt_q - ONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx  = tx_q;
  assign irq = empty && (state_q == S_IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: register vector table plus serial-frame
// sequences for back-to-back, overflow, collision, reset and DIV changes.
module tb_uart_tx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic tx, irq;
  uart_tx_if bus ();

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  uart_tx #(.FIFO_DEPTH(8), .DIV_WIDTH(16), .DIV_RESET(434)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx),
    .irq (irq)
  );

  typedef struct {
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [3:0]  raddr;
    logic [31:0] exp;
    logic [1:0]  exp_txirq;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_clear();
    bus.data_addr    = 4'h0;
    bus.data_wdata   = 32'h0;
    bus.data_wenable = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    bus.data_addr = a; bus.data_wdata = d; bus.data_wenable = we;
    @(negedge clk);
    bus_clear();
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string nm);
    bus.data_addr = a; bus.data_wenable = 4'h0;
    #1;
    chk(nm, bus.data_rdata, exp);
  endtask

  // First sample must be the first start-bit cycle of the frame.
  task automatic check_frame(input logic [7:0] b, input int d, input string nm);
    logic [9:0] fr;
    int errs;
    fr = {1'b1, b, 1'b0};
    errs = 0;
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < d; c++) begin
        @(negedge clk);
        if (tx !== fr[k]) errs++;
      end
    chk(nm, 32'(errs), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int errs;
    vec[0]  = '{4'h0, 32'h0,        4'h0, UART_STATUS, 32'h2,      2'b11};
    vec[1]  = '{4'h0, 32'h0,        4'h0, UART_DIV,    32'd434,    2'b11};
    vec[2]  = '{4'h0, 32'h0,        4'h0, UART_TXDATA, 32'h0,      2'b11};
    vec[3]  = '{4'h0, 32'h0,        4'h0, 4'hC,        32'h0,      2'b11};
    vec[4]  = '{UART_DIV, 32'h1234, 4'h3, UART_DIV,    32'h1234,   2'b11};
    vec[5]  = '{UART_DIV, 32'hFFAB, 4'h1, UART_DIV,    32'h12AB,   2'b11};
    vec[6]  = '{UART_DIV, 32'h5600, 4'h2, UART_DIV,    32'h56AB,   2'b11};
    vec[7]  = '{4'hC, 32'hFFFFFFFF, 4'hF, UART_DIV,    32'h56AB,   2'b11};
    vec[8]  = '{4'h5, 32'hFFFFFFFF, 4'hF, 4'h5,        32'h0,      2'b11};
    vec[9]  = '{UART_STATUS, 32'hF, 4'h1, UART_STATUS, 32'h2,      2'b11};
    vec[10] = '{UART_DIV, 32'hABCD0000, 4'hC, UART_DIV, 32'h56AB,  2'b11};
    vec[11] = '{UART_TXDATA, 32'h77, 4'h2, UART_STATUS, 32'h2,     2'b11};
    vec[12] = '{UART_DIV, 32'h0,    4'h3, UART_DIV,    32'h0,      2'b11};

    bus_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vec[i].we != 4'h0) wr(vec[i].waddr, vec[i].wdata, vec[i].we);
      else @(negedge clk);
      rd_chk(vec[i].raddr, vec[i].exp, $sformatf("vec%0d_rdata", i));
      chk($sformatf("vec%0d_txirq", i), 32'({tx, irq}), 32'(vec[i].exp_txirq));
    end

    // Single byte, DIV=4
    wr(UART_DIV, 32'd4, 4'h3);
    @(negedge clk);
    bus.data_addr = UART_TXDATA; bus.data_wdata = 32'h55; bus.data_wenable = 4'h1;
    @(negedge clk);
    bus_clear();
    chk("single_tx_hold", 32'(tx), 32'h1);
    chk("single_irq_fall", 32'(irq), 32'h0);
    rd_chk(UART_STATUS, 32'h0, "single_status_queued");
    check_frame(8'h55, 4, "single_frame");
    @(negedge clk);
    rd_chk(UART_STATUS, 32'h2, "single_status_done");
    chk("single_irq_rise", 32'({tx, irq}), 32'h3);

    // Back-to-back, DIV=2
    wr(UART_DIV, 32'd2, 4'h3);
    @(negedge clk);
    fork
      begin
        bus.data_addr = UART_TXDATA; bus.data_wenable = 4'h1; bus.data_wdata = 32'h41;
        @(negedge clk); bus.data_wdata = 32'h42;
        @(negedge clk); bus.data_wdata = 32'h43;
        @(negedge clk); bus_clear();
      end
      begin
        @(negedge clk);
        chk("b2b_tx_hold", 32'(tx), 32'h1);
        check_frame(8'h41, 2, "b2b_frame_A");
        check_frame(8'h42, 2, "b2b_frame_B");
        check_frame(8'h43, 2, "b2b_frame_C");
      end
    join
    @(negedge clk);
    rd_chk(UART_STATUS, 32'h2, "b2b_status_done");

    // Overflow, DIV=100
    wr(UART_DIV, 32'd100, 4'h3);
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          bus.data_addr = UART_TXDATA; bus.data_wenable = 4'h1; bus.data_wdata = 32'(i);
          @(negedge clk);
        end
        bus_clear();
        rd_chk(UART_STATUS, 32'hD, "ovf_status_set");
        bus.data_addr = UART_STATUS; bus.data_wdata = 32'h8; bus.data_wenable = 4'h1;
        @(negedge clk);
        bus_clear();
        rd_chk(UART_STATUS, 32'h5, "ovf_status_clr");
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 9; i++) check_frame(8'(i), 100, $sformatf("ovf_frame%0d", i));
      end
    join
    @(negedge clk);
    rd_chk(UART_STATUS, 32'h2, "ovf_status_idle");

    // Full FIFO push on the STOP-end pop cycle, DIV=2
    wr(UART_DIV, 32'd2, 4'h3);
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          bus.data_addr = UART_TXDATA; bus.data_wenable = 4'h1; bus.data_wdata = 32'h10 + 32'(i);
          @(negedge clk);
        end
        bus_clear();
        repeat (11) @(negedge clk);
        rd_chk(UART_STATUS, 32'h5, "col_status_full");
        @(negedge clk);
        bus.data_addr = UART_TXDATA; bus.data_wenable = 4'h1; bus.data_wdata = 32'h19;
        @(negedge clk);
        bus_clear();
        rd_chk(UART_STATUS, 32'h5, "col_status_after");
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 10; i++) check_frame(8'h10 + 8'(i), 2, $sformatf("col_frame%0d", i));
      end
    join
    @(negedge clk);
    rd_chk(UART_STATUS, 32'h2, "col_status_idle");

    // Reset during data bit 3 with a second byte queued
    wr(UART_DIV, 32'd4, 4'h3);
    @(negedge clk);
    bus.data_addr = UART_TXDATA; bus.data_wenable = 4'h1; bus.data_wdata = 32'hA5;
    @(negedge clk); bus.data_wdata = 32'h3C;
    @(negedge clk); bus_clear();
    repeat (17) @(negedge clk);
    chk("rst_pre_tx_bit3", 32'(tx), 32'h0);
    #2 rst = 1'b1;
    #1 chk("rst_async_tx", 32'(tx), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    rd_chk(UART_STATUS, 32'h2, "rst_status");
    rd_chk(UART_DIV, 32'd434, "rst_div");
    chk("rst_irq", 32'(irq), 32'h1);
    errs = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1) errs++;
    end
    chk("rst_fifo_discarded", 32'(errs), 32'h0);

    // DIV change mid-frame: 4 for the current frame, 8 for the next
    wr(UART_DIV, 32'd4, 4'h3);
    @(negedge clk);
    fork
      begin
        bus.data_addr = UART_TXDATA; bus.data_wenable = 4'h1; bus.data_wdata = 32'h96;
        @(negedge clk); bus.data_wdata = 32'h69;
        @(negedge clk); bus_clear();
        repeat (8) @(negedge clk);
        bus.data_addr = UART_DIV; bus.data_wenable = 4'h3; bus.data_wdata = 32'd8;
        @(negedge clk); bus_clear();
      end
      begin
        @(negedge clk);
        check_frame(8'h96, 4, "divchg_frame_old");
        check_frame(8'h69, 8, "divchg_frame_new");
      end
    join
    @(negedge clk);
    rd_chk(UART_DIV, 32'd8, "divchg_div");
    rd_chk(UART_STATUS, 32'h2, "divchg_status");

    // DIV=0 behaves as one-cycle bits
    wr(UART_DIV, 32'd0, 4'h3);
    @(negedge clk);
    bus.data_addr = UART_TXDATA; bus.data_wenable = 4'h1; bus.data_wdata = 32'hF0;
    @(negedge clk);
    bus_clear();
    chk("div0_tx_hold", 32'(tx), 32'h1);
    check_frame(8'hF0, 1, "div0_frame");
    @(negedge clk);
    rd_chk(UART_STATUS, 32'h2, "div0_status");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
